// File: rtl/register_bank_if.sv
// Register bank bus: write port, two read ports, operand loads.
// master drives indices/data/loads, slave returns read data and flags.
interface register_bank_if;
  logic        RegWrite;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] WriteReg;
  logic [31:0] WriteData;
  logic        LoadA;
  logic        LoadB;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] A_Out;
  logic [31:0] B_Out;
  logic        DestErr;

  modport master (
    output RegWrite, ReadReg1, ReadReg2,
    output WriteReg, WriteData,
    output LoadA, LoadB,
    input  ReadData1, ReadData2,
    input  A_Out, B_Out, DestErr
  );

  modport slave (
    input  RegWrite, ReadReg1, ReadReg2,
    input  WriteReg, WriteData,
    input  LoadA, LoadB,
    output ReadData1, ReadData2,
    output A_Out, B_Out, DestErr
  );
endinterface

// File: rtl/register_bank.sv
// 32x32 MIPS register file with A/B operand registers.
// $zero hardwired, SP preloaded at reset, write-first bypass into A/B.
module register_bank #(
  parameter int          SP_INDEX = 29,
  parameter logic [31:0] SP_RESET = 32'd227
) (
  input logic            clk,
  input logic            reset,
  register_bank_if.slave bus
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        dest_err_q, dest_err_d;

  logic [4:0]  wr_idx;
  logic        wr_hi_bad;
  logic        wr_ok;
  logic [4:0]  rd1;
  logic [4:0]  rd2;

  assign wr_idx    = bus.WriteReg[4:0];
  assign wr_hi_bad = |bus.WriteReg[31:5];
  assign wr_ok     = bus.RegWrite & ~wr_hi_bad
                   & (wr_idx != 5'd0);
  assign rd1       = bus.ReadReg1;
  assign rd2       = bus.ReadReg2;

  // Read ports see the stored array only; a write shows up next cycle.
  always_comb begin
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    if (rd1 != 5'd0) bus.ReadData1 = regs_q[rd1];
    if (rd2 != 5'd0) bus.ReadData2 = regs_q[rd2];
  end

  assign bus.A_Out   = a_q;
  assign bus.B_Out   = b_q;
  assign bus.DestErr = dest_err_q;

  // Next array contents: qualified write only, index 0 never touched.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok) begin
      regs_d[wr_idx] = bus.WriteData;
    end
  end

  // Operand capture with write-first bypass; index 0 always yields 0.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (bus.LoadA) begin
      if (rd1 == 5'd0) begin
        a_d = '0;
      end else if (wr_ok && wr_idx == rd1) begin
        a_d = bus.WriteData;
      end else begin
        a_d = regs_q[rd1];
      end
    end
    if (bus.LoadB) begin
      if (rd2 == 5'd0) begin
        b_d = '0;
      end else if (wr_ok && wr_idx == rd2) begin
        b_d = bus.WriteData;
      end else begin
        b_d = regs_q[rd2];
      end
    end
  end

  // Sticky flag for any write aimed past the 5-bit index range.
  always_comb begin
    dest_err_d = dest_err_q | (bus.RegWrite & wr_hi_bad);
  end

  // State update; reset loads SP and clears everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
      a_q        <= '0;
      b_q        <= '0;
      dest_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      a_q        <= a_d;
      b_q        <= b_d;
      dest_err_q <= dest_err_d;
    end
  end

endmodule
